// File: rtl/br_context_stream_mem.sv
// Branch-context store: loader write port plus a valid/ready streaming read engine
// with optional continuous replay of a [base, base+length) window.
module br_context_stream_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              wrap_en,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PtrOne = 1;
    localparam logic [ADDR_W:0]   RemOne = 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    logic [DATA_W-1:0] mem [Depth];
    logic [DATA_W-1:0] mem_q;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              wrap_q, wrap_d;
    logic              inflight_q, inflight_d;
    logic              infl_last_q, infl_last_d;
    logic [DATA_W-1:0] buf_data_q [2];
    logic [DATA_W-1:0] buf_data_d [2];
    logic              buf_last_q [2];
    logic              buf_last_d [2];
    logic [1:0]        count_q, count_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic pop, pop_buf, push, slot1, issue, issue_last;

    // Memory array has no reset so contents survive it; read before write gives old data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (issue) begin
            mem_q <= mem[rd_ptr_q];
        end
    end

    always_comb begin
        pop        = out_valid && out_ready;
        pop_buf    = pop && (count_q != 2'd0);
        // The in-flight word bypasses the buffer only when it is consumed straight away.
        push       = inflight_q && !(pop && (count_q == 2'd0));
        slot1      = (count_q == 2'd2) || ((count_q == 2'd1) && !pop_buf);
        issue      = (state_q == StRun) && !abort && ((count_q + {1'b0, inflight_q}) < 2'd2);
        issue_last = (remain_q == RemOne);

        buf_data_d = buf_data_q;
        buf_last_d = buf_last_q;
        if (pop_buf) begin
            buf_data_d[0] = buf_data_q[1];
            buf_last_d[0] = buf_last_q[1];
        end
        if (push) begin
            if (slot1) begin
                buf_data_d[1] = mem_q;
                buf_last_d[1] = infl_last_q;
            end else begin
                buf_data_d[0] = mem_q;
                buf_last_d[0] = infl_last_q;
            end
        end
        count_d     = count_q - {1'b0, pop_buf} + {1'b0, push};
        inflight_d  = issue;
        infl_last_d = issue && issue_last;

        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        base_d   = base_q;
        remain_d = remain_q;
        len_d    = len_q;
        wrap_d   = wrap_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    base_d   = base_addr;
                    rd_ptr_d = base_addr;
                    len_d    = length;
                    remain_d = length;
                    wrap_d   = wrap_en;
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                err_d = start;
                if (issue) begin
                    if (issue_last) begin
                        if (wrap_q) begin
                            rd_ptr_d = base_q;
                            remain_d = len_q;
                        end else begin
                            state_d = StDrain;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + PtrOne;
                        remain_d = remain_q - RemOne;
                    end
                end
            end
            StDrain: begin
                err_d = start;
                if ((count_d == 2'd0) && !inflight_d) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort && (state_q != StIdle)) begin
            state_d    = StIdle;
            count_d    = 2'd0;
            inflight_d = 1'b0;
            done_d     = 1'b0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            rd_ptr_q    <= '0;
            base_q      <= '0;
            remain_q    <= '0;
            len_q       <= '0;
            wrap_q      <= 1'b0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            buf_data_q  <= '{default: '0};
            buf_last_q  <= '{default: 1'b0};
            count_q     <= 2'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            base_q      <= base_d;
            remain_q    <= remain_d;
            len_q       <= len_d;
            wrap_q      <= wrap_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            buf_data_q  <= buf_data_d;
            buf_last_q  <= buf_last_d;
            count_q     <= count_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        out_valid = (count_q != 2'd0) || inflight_q;
        out_data  = '0;
        out_last  = 1'b0;
        if (count_q != 2'd0) begin
            out_data = buf_data_q[0];
            out_last = buf_last_q[0];
        end else if (inflight_q) begin
            out_data = mem_q;
            out_last = infl_last_q;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_br_context_stream_mem.sv
// Directed bench: a 16-bit-address instance for streaming/wrap/abort/reset and a
// 4-bit-address instance for pointer wrap-around at the top of memory.
module tb_br_context_stream_mem;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_wr_en, a_start, a_wrap, a_abort, a_ready;
    logic [15:0] a_wr_addr, a_base;
    logic [7:0]  a_wr_data;
    logic [16:0] a_len;
    logic        a_valid, a_last, a_busy, a_done, a_err;
    logic [7:0]  a_data;

    logic        b_wr_en, b_start, b_wrap, b_abort, b_ready;
    logic [3:0]  b_wr_addr, b_base;
    logic [7:0]  b_wr_data;
    logic [4:0]  b_len;
    logic        b_valid, b_last, b_busy, b_done, b_err;
    logic [7:0]  b_data;

    br_context_stream_mem #(.DATA_W(8), .ADDR_W(16)) u_dut_a (
        .clk(clk), .reset(reset), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .start(a_start), .base_addr(a_base), .length(a_len), .wrap_en(a_wrap),
        .abort(a_abort), .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data),
        .out_last(a_last), .busy(a_busy), .done(a_done), .err(a_err)
    );

    br_context_stream_mem #(.DATA_W(8), .ADDR_W(4)) u_dut_b (
        .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .start(b_start), .base_addr(b_base), .length(b_len), .wrap_en(b_wrap),
        .abort(b_abort), .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data),
        .out_last(b_last), .busy(b_busy), .done(b_done), .err(b_err)
    );

    int errors = 0;
    int checks = 0;
    int idx;
    logic [3:0] b_addrs [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
    logic [7:0] b_words [4] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Plain 16-word pass from base 0 with the consumer always ready.
    task automatic full_stream(input string tag);
        a_base  = 16'd0;
        a_len   = 17'd16;
        a_wrap  = 1'b0;
        a_ready = 1'b1;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check({tag, "_lat_valid"}, 32'(a_valid), 32'd0);
        tick();
        for (int k = 0; k < 16; k++) begin
            check({tag, "_valid"}, 32'(a_valid), 32'd1);
            check({tag, "_data"}, 32'(a_data), 32'h80 + k);
            check({tag, "_last"}, 32'(a_last), 32'(k == 15));
            check({tag, "_nodone"}, 32'(a_done), 32'd0);
            tick();
        end
        check({tag, "_done"}, 32'(a_done), 32'd1);
        check({tag, "_idle"}, 32'(a_busy), 32'd0);
        check({tag, "_empty"}, 32'(a_valid), 32'd0);
        tick();
        check({tag, "_done_pulse"}, 32'(a_done), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_start = 1'b0; a_base = '0;
        a_len = '0; a_wrap = 1'b0; a_abort = 1'b0; a_ready = 1'b0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_start = 1'b0; b_base = '0;
        b_len = '0; b_wrap = 1'b0; b_abort = 1'b0; b_ready = 1'b0;
        #12;
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_data", 32'(a_data), 32'd0);
        check("rst_last", 32'(a_last), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_err", 32'(a_err), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) begin
            a_wr_en   = 1'b1;
            a_wr_addr = 16'(i);
            a_wr_data = 8'h80 + 8'(i);
            b_wr_en   = (i < 4);
            b_wr_addr = b_addrs[i % 4];
            b_wr_data = b_words[i % 4];
            tick();
        end
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;

        full_stream("s1");

        // Alternating ready: every beat must show the next expected word, stalls included.
        a_base = 16'd0; a_len = 17'd16; a_wrap = 1'b0; a_ready = 1'b0; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        idx = 0;
        for (int c = 0; c < 80 && idx < 16; c++) begin
            a_ready = ((c % 2) == 0);
            if (a_valid) begin
                check("alt_data", 32'(a_data), 32'h80 + idx);
                check("alt_last", 32'(a_last), 32'(idx == 15));
                if (a_ready) idx++;
            end
            tick();
        end
        check("alt_count", 32'(idx), 32'd16);
        check("alt_done", 32'(a_done), 32'd1);
        a_ready = 1'b1;
        tick();

        // Pointer wrap from 15 to 0 on the 4-bit instance.
        b_base = 4'd14; b_len = 5'd4; b_wrap = 1'b0; b_ready = 1'b1; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("pw_valid", 32'(b_valid), 32'd1);
            check("pw_data", 32'(b_data), 32'(b_words[k]));
            check("pw_last", 32'(b_last), 32'(k == 3));
            tick();
        end
        check("pw_done", 32'(b_done), 32'd1);
        check("pw_busy", 32'(b_busy), 32'd0);
        check("pw_err", 32'(b_err), 32'd0);

        // Continuous replay of a 3-word window, a stray start, then abort.
        a_base = 16'd0; a_len = 17'd3; a_wrap = 1'b1; a_ready = 1'b1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            check("wr_valid", 32'(a_valid), 32'd1);
            check("wr_data", 32'(a_data), 32'h80 + (k % 3));
            check("wr_last", 32'(a_last), 32'((k % 3) == 2));
            check("wr_err", 32'(a_err), 32'(k == 3));
            a_start = (k == 2);
            a_len   = (k == 2) ? 17'd5 : 17'd3;
            tick();
        end
        a_start = 1'b0;
        check("wr_pre_abort", 32'(a_data), 32'h82);
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        check("ab_valid", 32'(a_valid), 32'd0);
        check("ab_busy", 32'(a_busy), 32'd0);
        check("ab_done", 32'(a_done), 32'd0);
        tick();
        check("ab_done2", 32'(a_done), 32'd0);
        check("ab_valid2", 32'(a_valid), 32'd0);

        // Zero-length start completes immediately.
        a_len = 17'd0; a_wrap = 1'b0; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("z_done", 32'(a_done), 32'd1);
        check("z_valid", 32'(a_valid), 32'd0);
        check("z_busy", 32'(a_busy), 32'd0);
        tick();
        check("z_done_pulse", 32'(a_done), 32'd0);
        check("z_valid2", 32'(a_valid), 32'd0);

        // Asynchronous reset mid-stream, then restart from retained memory.
        a_base = 16'd0; a_len = 17'd16; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        tick();
        check("mr_data", 32'(a_data), 32'h81);
        #2;
        reset = 1'b1;
        #1;
        check("mr_valid", 32'(a_valid), 32'd0);
        check("mr_busy", 32'(a_busy), 32'd0);
        check("mr_data0", 32'(a_data), 32'd0);
        check("mr_last", 32'(a_last), 32'd0);
        #3;
        reset = 1'b0;
        tick();
        full_stream("s6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
